// File: rtl/dnn_loader_if.sv
// dnn_loader_if: bundles the operand stream, the 28-operand fan-out and the
// fire/result handshake between the loader and the inference stage.
// WEIGHT_REUSE_EN adds the wt_hold sideband on the stream.
interface dnn_loader_if;
    logic       s_valid;
    logic [4:0] s_data;        // two's complement operand
    logic       s_last;
    logic       s_ready;
`ifdef WEIGHT_REUSE_EN
    logic       wt_hold;
`endif
    logic [4:0] x0, x1, x2, x3;
    logic [4:0] w04, w05, w06, w07, w14, w15, w16, w17;
    logic [4:0] w24, w25, w26, w27, w34, w35, w36, w37;
    logic [4:0] w48, w49, w58, w59, w68, w69, w78, w79;
    logic       in_ready;
    logic       res_valid;
    logic       frame_err;
    logic [7:0] frame_cnt;

`ifdef WEIGHT_REUSE_EN
    modport slave (
        input  s_valid, s_data, s_last, wt_hold, res_valid,
        output s_ready, in_ready, frame_err, frame_cnt,
        output x0, x1, x2, x3,
        output w04, w05, w06, w07, w14, w15, w16, w17,
        output w24, w25, w26, w27, w34, w35, w36, w37,
        output w48, w49, w58, w59, w68, w69, w78, w79
    );
    modport master (
        output s_valid, s_data, s_last, wt_hold, res_valid,
        input  s_ready, in_ready, frame_err, frame_cnt,
        input  x0, x1, x2, x3,
        input  w04, w05, w06, w07, w14, w15, w16, w17,
        input  w24, w25, w26, w27, w34, w35, w36, w37,
        input  w48, w49, w58, w59, w68, w69, w78, w79
    );
`else
    modport slave (
        input  s_valid, s_data, s_last, res_valid,
        output s_ready, in_ready, frame_err, frame_cnt,
        output x0, x1, x2, x3,
        output w04, w05, w06, w07, w14, w15, w16, w17,
        output w24, w25, w26, w27, w34, w35, w36, w37,
        output w48, w49, w58, w59, w68, w69, w78, w79
    );
    modport master (
        output s_valid, s_data, s_last, res_valid,
        input  s_ready, in_ready, frame_err, frame_cnt,
        input  x0, x1, x2, x3,
        input  w04, w05, w06, w07, w14, w15, w16, w17,
        input  w24, w25, w26, w27, w34, w35, w36, w37,
        input  w48, w49, w58, w59, w68, w69, w78, w79
    );
`endif
endinterface

// File: rtl/dnn_loader.sv
// dnn_loader: assembles a serial stream of 5-bit operands into the 28 parallel
// inputs/weights of the 4-4-2 ReLU stage, fires it, then waits for its result.
// Optional feature macro: WEIGHT_REUSE_EN (wt_hold selects 4-beat input-only
// frames once a good frame has loaded the weights).
//
// state | meaning
// LOAD  | accepting beats, s_ready high
// FIRE  | full frame held, in_ready high for this one cycle
// WAIT  | operands frozen, waiting for res_valid or timeout
module dnn_loader #(
    parameter int TIMEOUT = 15
) (
    input logic         clk,
    input logic         rst,
    dnn_loader_if.slave bus
);
    localparam int         FRAME_LEN  = 28;
    localparam logic [4:0] LAST_FULL  = 5'(FRAME_LEN - 1);
    localparam logic [4:0] LAST_SHORT = 5'd3;

    typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

    state_t     state, state_n;
    logic [4:0] idx, idx_n;
    logic [3:0] wait_cnt, wait_cnt_n;
    logic [7:0] frame_cnt_q, frame_cnt_n;
    logic       s_ready_q, in_ready_q, frame_err_q, err_n;
    logic [4:0] ops [FRAME_LEN];
    logic       accept, short_frame;
    logic [4:0] last_idx;

    assign accept   = bus.s_valid && s_ready_q;
    assign last_idx = short_frame ? LAST_SHORT : LAST_FULL;

`ifdef WEIGHT_REUSE_EN
    logic weights_valid, short_q;

    // The frame length is decided by wt_hold on the first beat and held for the rest of the frame.
    assign short_frame = (idx == 5'd0) ? (bus.wt_hold && weights_valid) : short_q;

    // Track frame length and whether a well-formed full frame has loaded the weights.
    always_ff @(posedge clk) begin
        if (rst) begin
            weights_valid <= 1'b0;
            short_q       <= 1'b0;
        end else begin
            if (accept && idx == 5'd0) short_q <= short_frame;
            if (state == FIRE)         weights_valid <= 1'b1;
        end
    end
`else
    assign short_frame = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    // Next-state and next-value logic.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        wait_cnt_n  = wait_cnt;
        frame_cnt_n = frame_cnt_q;
        err_n       = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    if (bus.s_last && idx == last_idx) begin
                        state_n = FIRE;
                        idx_n   = 5'd0;
                    end else if (bus.s_last || idx == last_idx) begin
                        err_n = 1'b1;
                        idx_n = 5'd0;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            FIRE: begin
                state_n    = WAIT;
                wait_cnt_n = 4'(TIMEOUT - 1);   // down-counter: terminal count 0 ends the last WAIT cycle
            end
            WAIT: begin
                if (bus.res_valid) begin
                    frame_cnt_n = frame_cnt_q + 8'd1;
                    state_n     = LOAD;
                end else if (wait_cnt == 4'd0) begin
                    err_n   = 1'b1;
                    state_n = LOAD;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
            default: state_n = LOAD;
        endcase
    end

    // Registered datapath, strobes and operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 5'd0;
            wait_cnt    <= 4'd0;
            frame_cnt_q <= 8'd0;
            s_ready_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) ops[i] <= 5'd0;
        end else begin
            idx         <= idx_n;
            wait_cnt    <= wait_cnt_n;
            frame_cnt_q <= frame_cnt_n;
            s_ready_q   <= (state_n == LOAD);
            in_ready_q  <= (state_n == FIRE);
            frame_err_q <= err_n;
            if (accept) ops[idx] <= bus.s_data;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.frame_err = frame_err_q;
    assign bus.frame_cnt = frame_cnt_q;

    assign bus.x0  = ops[0];
    assign bus.x1  = ops[1];
    assign bus.x2  = ops[2];
    assign bus.x3  = ops[3];
    assign bus.w04 = ops[4];
    assign bus.w05 = ops[5];
    assign bus.w06 = ops[6];
    assign bus.w07 = ops[7];
    assign bus.w14 = ops[8];
    assign bus.w15 = ops[9];
    assign bus.w16 = ops[10];
    assign bus.w17 = ops[11];
    assign bus.w24 = ops[12];
    assign bus.w25 = ops[13];
    assign bus.w26 = ops[14];
    assign bus.w27 = ops[15];
    assign bus.w34 = ops[16];
    assign bus.w35 = ops[17];
    assign bus.w36 = ops[18];
    assign bus.w37 = ops[19];
    assign bus.w48 = ops[20];
    assign bus.w49 = ops[21];
    assign bus.w58 = ops[22];
    assign bus.w59 = ops[23];
    assign bus.w68 = ops[24];
    assign bus.w69 = ops[25];
    assign bus.w78 = ops[26];
    assign bus.w79 = ops[27];
endmodule

// File: tb/tb_dnn_loader.sv
// tb_dnn_loader: directed frames into dnn_loader; expected strobes (fire/error)
// are queued by the stimulus and checked by a negedge monitor.
module tb_dnn_loader;
    typedef logic [27:0][4:0] ops_t;
    typedef struct {
        int         kind;   // 1 = in_ready, 2 = frame_err
        int         cyc;
        ops_t       ops;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    ops_t model = '0;
    logic [7:0] exp_cnt = 8'd0;
    exp_t q[$];
    exp_t mon_e;
`ifdef WEIGHT_REUSE_EN
    logic hold_cfg = 1'b0;
`endif

    dnn_loader_if bus();
    dnn_loader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ops_t pack_ops();
        return {bus.w79, bus.w78, bus.w69, bus.w68, bus.w59, bus.w58, bus.w49, bus.w48,
                bus.w37, bus.w36, bus.w35, bus.w34, bus.w27, bus.w26, bus.w25, bus.w24,
                bus.w17, bus.w16, bus.w15, bus.w14, bus.w07, bus.w06, bus.w05, bus.w04,
                bus.x3, bus.x2, bus.x1, bus.x0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ops(input string name, input ops_t act, input ops_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.ops  = model;
        e.cnt  = exp_cnt;
        q.push_back(e);
    endtask

    // Scoreboard monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (bus.in_ready || bus.frame_err)) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: in_ready=%0b frame_err=%0b at cycle %0d, expected none",
                         bus.in_ready, bus.frame_err, cyc);
            end else begin
                mon_e = q.pop_front();
                check("strobe_kind", bus.in_ready ? 32'd1 : 32'd2, 32'(mon_e.kind));
                check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("frame_cnt_at_strobe", 32'(bus.frame_cnt), 32'(mon_e.cnt));
                if (mon_e.kind == 1) begin
                    check_ops("operands_at_fire", pack_ops(), mon_e.ops);
                    check("s_ready_in_fire", 32'(bus.s_ready), 32'd0);
                end
            end
        end
    end

    // Drive one beat and hold it until accepted; c returns the accept-edge cycle.
    task automatic send_beat(input logic [4:0] d, input logic l, output int c);
        logic rdy;
        int   waits;
        rdy   = 1'b0;
        waits = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
`ifdef WEIGHT_REUSE_EN
        bus.wt_hold = hold_cfg;
`endif
        while (!rdy && waits < 100) begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL beat_accept: s_ready stayed %0b for %0d cycles, expected 1", rdy, waits);
        end
        c = cyc;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input ops_t v, input int n, input int last_pos,
                              output int first_c, output int last_c);
        int c;
        first_c = 0;
        last_c  = 0;
        for (int k = 0; k < n; k++) begin
            send_beat(v[k], (k == last_pos), c);
            if (k == 0) first_c = c;
            last_c   = c;
            model[k] = v[k];
        end
    endtask

    // Result strobe in the first WAIT cycle, then confirm the count and reopened stream.
    task automatic respond_ok();
        @(posedge clk); #1;
        bus.res_valid = 1'b1;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("frame_cnt_after_result", 32'(bus.frame_cnt), 32'(exp_cnt));
        check("s_ready_after_result", 32'(bus.s_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ops_t v_up, v_alt, v_down, v_neg, v_pos, v_x;
        int fc, lc, fc2, lc2;
        bus.s_valid   = 1'b0;
        bus.s_data    = 5'd0;
        bus.s_last    = 1'b0;
        bus.res_valid = 1'b0;
`ifdef WEIGHT_REUSE_EN
        bus.wt_hold   = 1'b0;
`endif
        for (int i = 0; i < 28; i++) begin
            v_up[i]   = 5'(i + 1);
            v_alt[i]  = 5'(i + 3);
            v_down[i] = 5'(31 - i);
            v_neg[i]  = 5'b10000;
            v_pos[i]  = 5'b01111;
        end
        v_x = '0;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_ops("reset_ops", pack_ops(), '0);
        check("reset_s_ready", 32'(bus.s_ready), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst = 1'b0;

        // Full frame 1..28.
        send_frame(v_up, 28, 27, fc, lc);
        push(1, lc);
        check("x0_first_frame", 32'(bus.x0), 32'd1);
        check("w04_first_frame", 32'(bus.w04), 32'd5);
        check("w37_first_frame", 32'(bus.w37), 32'd20);
        check("w79_first_frame", 32'(bus.w79), 32'd28);
        respond_ok();

        // res_valid while loading is ignored.
        bus.res_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        check("res_valid_in_load_ignored", 32'(bus.frame_cnt), 32'(exp_cnt));

        // Early last on beat 10, then a good frame.
        send_frame(v_alt, 10, 9, fc, lc);
        push(2, lc);
        send_frame(v_down, 28, 27, fc, lc);
        push(1, lc);
        respond_ok();

        // 28 beats with no last; the next beat starts a new frame.
        send_frame(v_alt, 28, -1, fc, lc);
        push(2, lc);
        send_frame(v_up, 28, 27, fc, lc);
        push(1, lc);
        respond_ok();

        // Timeout: 15 WAIT cycles, and a beat offered during WAIT must not be consumed.
        send_frame(v_alt, 28, 27, fc, lc);
        push(1, lc);
        push(2, lc + 16);
        send_frame(v_down, 28, 27, fc2, lc2);
        check("held_beat_accept_cycle", 32'(fc2), 32'(lc + 17));
        push(1, lc2);
        respond_ok();

        // Signed extremes.
        send_frame(v_neg, 28, 27, fc, lc);
        push(1, lc);
        check("w79_min", 32'(bus.w79), 32'h10);
        respond_ok();
        send_frame(v_pos, 28, 27, fc, lc);
        push(1, lc);
        check("x0_max", 32'(bus.x0), 32'h0F);
        respond_ok();

`ifdef WEIGHT_REUSE_EN
        // Weight reuse: full frame, then a 4-beat -1..-4 input-only frame.
        send_frame(v_up, 28, 27, fc, lc);
        push(1, lc);
        respond_ok();
        v_x[0] = 5'h1F;
        v_x[1] = 5'h1E;
        v_x[2] = 5'h1D;
        v_x[3] = 5'h1C;
        hold_cfg = 1'b1;
        send_frame(v_x, 4, 3, fc, lc);
        hold_cfg = 1'b0;
        push(1, lc);
        check("reuse_w04_kept", 32'(bus.w04), 32'd5);
        respond_ok();
`endif

        // Mid-frame reset at idx 12: no error, everything back to reset values.
        send_frame(v_alt, 12, -1, fc, lc);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model   = '0;
        exp_cnt = 8'd0;
        check_ops("midreset_ops", pack_ops(), '0);
        check("midreset_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("midreset_frame_err", 32'(bus.frame_err), 32'd0);
        check("midreset_s_ready", 32'(bus.s_ready), 32'd0);
`ifdef WEIGHT_REUSE_EN
        hold_cfg = 1'b1;   // no good frame since reset: must still be a full frame
`endif
        send_frame(v_down, 28, 27, fc, lc);
`ifdef WEIGHT_REUSE_EN
        hold_cfg = 1'b0;
`endif
        push(1, lc);
        respond_ok();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dnn_loader.md
Name: dnn_loader

Overview:
- Upstream feeder for the 4-4-2 ReLU inference stage.
- Accepts a serial valid/ready stream of 5-bit signed operands and assembles them into the 28 parallel inputs and weights the inference stage needs.
- Pulses in_ready for exactly one cycle once a complete, well-formed frame is held.
- Waits for the stage's result strobe before accepting the next frame.

Parameters:
- FRAME_LEN, 28: beats per full frame (4 inputs + 16 layer-1 weights + 8 layer-2 weights); fixed, not overridable.
- TIMEOUT, 15: maximum cycles spent in WAIT before abandoning; 4-bit counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  stream beat valid.
- s_data  input  5  signed stream operand.
- s_last  input  1  marks the final beat of a frame.
- s_ready  output  1  loader accepts a beat this cycle.
- x0,x1,x2,x3  output  5 each  signed inputs.
- w04..w07,w14..w17,w24..w27,w34..w37  output  5 each  signed layer-1 weights.
- w48,w49,w58,w59,w68,w69,w78,w79  output  5 each  signed layer-2 weights.
- in_ready  output  1  one-cycle frame-fire strobe to the inference stage.
- res_valid  input  1  result strobe from the inference stage (its out0_ready).
- frame_err  output  1  one-cycle error pulse.
- frame_cnt  output  8  completed frames; wraps 255->0.

Behaviour:
- Reset values: all operand outputs 0, in_ready 0, frame_err 0, frame_cnt 0, s_ready 0 in the reset cycle, state LOAD, beat index 0.
- All outputs are registered.
- Beat acceptance: a beat is accepted when s_valid && s_ready.
- Beat order:
  - idx 0-3: x0..x3.
  - idx 4-19: w04,w05,w06,w07,w14..w17,w24..w27,w34..w37.
  - idx 20-27: w48,w49,w58,w59,w68,w69,w78,w79.
- Each accepted beat writes its target register on the next edge. The value is stored verbatim; no sign or width conversion.
- LOAD state: s_ready=1.
  - Accepted beat with idx<27 and s_last=0: idx++.
  - Accepted beat with idx=27 and s_last=1: go to FIRE, idx cleared.
  - Accepted beat with s_last=1 and idx<27 (early last), or idx=27 with s_last=0 (missing last): frame_err pulses next cycle, idx cleared, stay in LOAD, no in_ready.
  - Partially written operands after an error are don't-care until the next good frame overwrites them.
- FIRE state: s_ready=0, in_ready=1 for exactly one cycle; next state WAIT, wait counter cleared. Operand outputs are stable from the FIRE cycle until WAIT exits.
- WAIT state: s_ready=0.
  - res_valid=1: frame_cnt++ (wrap), go to LOAD.
  - Counter reaches TIMEOUT without res_valid: frame_err pulse, frame_cnt unchanged, go to LOAD.
  - res_valid in the same cycle as the timeout: treated as success.
- res_valid seen in LOAD or FIRE is ignored.
- s_valid while s_ready=0: the beat is not consumed; the upstream source must hold it.
- Nominal throughput: 28 beats + FIRE + 1 WAIT cycle (the inference stage registers one cycle after in_ready) = 30 cycles per frame.
- Reset in any state returns everything to reset values on the next edge; a mid-frame reset discards the partial frame with no frame_err.

Optional Feature:
- Macro: WEIGHT_REUSE_EN.
- When defined:
  - Adds input port wt_hold (1 bit), sampled on the first beat of a frame (idx=0).
  - If wt_hold=1 and at least one good frame has completed since reset, the frame is 4 beats (x0..x3). s_last is required at idx 3; the early/missing-last rules apply relative to idx 3. Weights are retained.
  - If wt_hold=1 before any good frame has completed, the frame is treated as a full 28-beat frame.
- When undefined: no wt_hold port; every frame is 28 beats.

Test Plan:
- Reset then one full frame of values 1..28 with s_last on beat 28 -> in_ready high exactly 1 cycle after the 28th accept; x0=1, w04=5, w37=20, w79=28; res_valid 1 cycle later -> frame_cnt=1, s_ready returns high.
- Frame with s_last on beat 10 -> frame_err single pulse, no in_ready; the following good frame fires normally.
- 28 beats with no s_last -> frame_err pulse; the 29th beat is taken as idx 0 of a new frame.
- Good frame, res_valid held low -> frame_err after 15 WAIT cycles, frame_cnt unchanged, s_ready high again; s_valid held during WAIT is not consumed.
- Signed extremes: all beats -16 -> every output 5'b10000; all beats +15 -> 5'b01111.
- WEIGHT_REUSE_EN defined: full frame, then a 4-beat frame of -1,-2,-3,-4 with wt_hold=1 -> in_ready fires; x0..x3 updated, weights unchanged. Also, rst asserted at idx 12 -> clean restart with no error pulse.
